// File: rtl/instr_encoder_if.sv
// Request/response bundle for the RV32I instruction encoder.
// The master side issues decoded requests and consumes encoded words.
interface instr_encoder_if;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  fmt;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [31:0] imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic        out_err;

    modport master (
        output in_valid, fmt, rd, rs1, rs2, funct3, imm, out_ready,
        input  in_ready, out_valid, out_instr, out_err
    );

    modport slave (
        input  in_valid, fmt, rd, rs1, rs2, funct3, imm, out_ready,
        output in_ready, out_valid, out_instr, out_err
    );
endinterface

// File: rtl/instr_encoder.sv
// Builds RV32I instruction words from decoded fields, flags out-of-range immediates,
// and queues results in a small valid/ready output FIFO.
module instr_encoder #(
    parameter int unsigned FIFO_DEPTH = 2,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    instr_encoder_if.slave   bus,
    output logic [CNT_W-1:0] enc_cnt,
    output logic [CNT_W-1:0] err_cnt
);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0] FullCnt = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        FmtLoad   = 3'd0,
        FmtStore  = 3'd1,
        FmtOpImm  = 3'd2,
        FmtBranch = 3'd3,
        FmtJal    = 3'd4,
        FmtJalr   = 3'd5,
        FmtAuipc  = 3'd6,
        FmtLui    = 3'd7
    } fmt_e;

    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpOpImm  = 7'b0010011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] OpLui    = 7'b0110111;

    logic [31:0] imm;
    logic [31:0] enc_instr;
    logic        enc_err;
    logic        imm12_ok;
    logic        imm13_ok;
    logic        imm21_ok;
    logic        upper_ok;

    assign imm = bus.imm;

    // A sign-extended N-bit immediate has all bits above N-2 equal to the sign bit.
    assign imm12_ok = (&imm[31:11]) | ~(|imm[31:11]);
    assign imm13_ok = ((&imm[31:12]) | ~(|imm[31:12])) & ~imm[0];
    assign imm21_ok = ((&imm[31:20]) | ~(|imm[31:20])) & ~imm[0];
    assign upper_ok = ~(|imm[11:0]);

    always_comb begin
        enc_instr = '0;
        enc_err   = 1'b0;
        unique case (fmt_e'(bus.fmt))
            FmtLoad: begin
                enc_instr = {imm[11:0], bus.rs1, bus.funct3, bus.rd, OpLoad};
                enc_err   = ~imm12_ok;
            end
            FmtStore: begin
                enc_instr = {imm[11:5], bus.rs2, bus.rs1, bus.funct3, imm[4:0], OpStore};
                enc_err   = ~imm12_ok;
            end
            FmtOpImm: begin
                enc_instr = {imm[11:0], bus.rs1, bus.funct3, bus.rd, OpOpImm};
                enc_err   = ~imm12_ok;
            end
            FmtBranch: begin
                enc_instr = {imm[12], imm[10:5], bus.rs2, bus.rs1, bus.funct3, imm[4:1], imm[11],
                             OpBranch};
                enc_err   = ~imm13_ok;
            end
            FmtJal: begin
                enc_instr = {imm[20], imm[10:1], imm[11], imm[19:12], bus.rd, OpJal};
                enc_err   = ~imm21_ok;
            end
            FmtJalr: begin
                enc_instr = {imm[11:0], bus.rs1, 3'b000, bus.rd, OpJalr};
                enc_err   = ~imm12_ok;
            end
            FmtAuipc: begin
                enc_instr = {imm[31:12], bus.rd, OpAuipc};
                enc_err   = ~upper_ok;
            end
            FmtLui: begin
                enc_instr = {imm[31:12], bus.rd, OpLui};
                enc_err   = ~upper_ok;
            end
            default: begin
                enc_instr = '0;
                enc_err   = 1'b0;
            end
        endcase
    end

    // Each entry holds {err, instr}.
    logic [32:0]      mem_q [FIFO_DEPTH];
    logic [32:0]      mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic [CNT_W-1:0] enc_cnt_q, enc_cnt_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic             full;
    logic             push;
    logic             pop;

    assign full          = (count_q == FullCnt);
    assign bus.in_ready  = ~full & ~rst;
    assign bus.out_valid = (count_q != '0);
    assign bus.out_instr = bus.out_valid ? mem_q[rd_ptr_q][31:0] : 32'h0;
    assign bus.out_err   = bus.out_valid & mem_q[rd_ptr_q][32];
    assign push          = bus.in_valid & bus.in_ready;
    assign pop           = bus.out_valid & bus.out_ready;
    assign enc_cnt       = enc_cnt_q;
    assign err_cnt       = err_cnt_q;

    always_comb begin
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        enc_cnt_d = enc_cnt_q;
        err_cnt_d = err_cnt_q;
        if (push) begin
            mem_d[wr_ptr_q] = {enc_err, enc_instr};
            wr_ptr_d        = wr_ptr_q + 1'b1;
            enc_cnt_d       = enc_cnt_q + 1'b1;
            if (enc_err && !(&err_cnt_q)) begin
                err_cnt_d = err_cnt_q + 1'b1;
            end
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q     <= '{default: '0};
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            enc_cnt_q <= '0;
            err_cnt_q <= '0;
        end else begin
            mem_q     <= mem_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            enc_cnt_q <= enc_cnt_d;
            err_cnt_q <= err_cnt_d;
        end
    end
endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: hand-computed RV32I words, error flags,
// FIFO backpressure and asynchronous reset.
module tb_instr_encoder;
    logic        clk;
    logic        rst;
    logic [15:0] enc_cnt;
    logic [15:0] err_cnt;
    int          n_asserts;
    int          n_fail;

    instr_encoder_if bus();

    instr_encoder #(
        .FIFO_DEPTH(2),
        .CNT_W     (16)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .bus    (bus),
        .enc_cnt(enc_cnt),
        .err_cnt(err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] f, input logic [4:0] d, input logic [4:0] s1,
                         input logic [4:0] s2, input logic [2:0] f3, input logic [31:0] im);
        bus.fmt    = f;
        bus.rd     = d;
        bus.rs1    = s1;
        bus.rs2    = s2;
        bus.funct3 = f3;
        bus.imm    = im;
    endtask

    // One accepted request; called one time unit after a rising edge.
    task automatic send(input string tag, input logic [2:0] f, input logic [4:0] d,
                        input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f3,
                        input logic [31:0] im);
        drive(f, d, s1, s2, f3, im);
        bus.in_valid = 1'b1;
        chk({tag, "_in_ready"}, {31'b0, bus.in_ready}, 32'd1);
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic head(input string tag, input logic [31:0] instr, input logic err,
                        input logic [15:0] encc, input logic [15:0] errc);
        chk({tag, "_valid"}, {31'b0, bus.out_valid}, 32'd1);
        chk({tag, "_instr"}, bus.out_instr, instr);
        chk({tag, "_err"}, {31'b0, bus.out_err}, {31'b0, err});
        chk({tag, "_enc_cnt"}, {16'b0, enc_cnt}, {16'b0, encc});
        chk({tag, "_err_cnt"}, {16'b0, err_cnt}, {16'b0, errc});
    endtask

    initial begin
        n_asserts    = 0;
        n_fail       = 0;
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        drive(3'd0, 5'd0, 5'd0, 5'd0, 3'd0, 32'h0);
        tick();
        chk("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("rst_in_ready", {31'b0, bus.in_ready}, 32'd0);
        chk("rst_out_instr", bus.out_instr, 32'h0);
        chk("rst_enc_cnt", {16'b0, enc_cnt}, 32'd0);
        chk("rst_err_cnt", {16'b0, err_cnt}, 32'd0);
        tick();
        rst = 1'b0;
        tick();
        chk("idle_in_ready", {31'b0, bus.in_ready}, 32'd1);

        // Streaming with out_ready=1: each push pairs with the pop of the previous entry.
        send("lui", 3'd7, 5'd5, 5'd0, 5'd0, 3'd0, 32'h12345000);
        head("lui", 32'h123452B7, 1'b0, 16'd1, 16'd0);
        send("jal", 3'd4, 5'd1, 5'd0, 5'd0, 3'd0, 32'h00000008);
        head("jal", 32'h008000EF, 1'b0, 16'd2, 16'd0);
        send("beq_neg", 3'd3, 5'd0, 5'd1, 5'd2, 3'd0, 32'hFFFFFFFC);
        head("beq_neg", 32'hFE208EE3, 1'b0, 16'd3, 16'd0);
        send("beq_odd", 3'd3, 5'd0, 5'd1, 5'd2, 3'd0, 32'h00000003);
        head("beq_odd", 32'h00208163, 1'b1, 16'd4, 16'd1);
        send("addi_2048", 3'd2, 5'd3, 5'd4, 5'd0, 3'd0, 32'h00000800);
        head("addi_2048", 32'h80020193, 1'b1, 16'd5, 16'd2);
        send("addi_m2048", 3'd2, 5'd3, 5'd4, 5'd0, 3'd0, 32'hFFFFF800);
        head("addi_m2048", 32'h80020193, 1'b0, 16'd6, 16'd2);
        send("lui_low", 3'd7, 5'd5, 5'd0, 5'd0, 3'd0, 32'h00001001);
        head("lui_low", 32'h000012B7, 1'b1, 16'd7, 16'd3);
        send("auipc", 3'd6, 5'd2, 5'd0, 5'd0, 3'd0, 32'h00001000);
        head("auipc", 32'h00001117, 1'b0, 16'd8, 16'd3);
        tick();
        chk("drain_empty", {31'b0, bus.out_valid}, 32'd0);
        chk("drain_instr", bus.out_instr, 32'h0);

        // Backpressure: lw, sw, jalr with the consumer stalled.
        bus.out_ready = 1'b0;
        send("bp_lw", 3'd0, 5'd5, 5'd1, 5'd0, 3'd2, 32'h00000004);
        head("bp_lw", 32'h0040A283, 1'b0, 16'd9, 16'd3);
        send("bp_sw", 3'd1, 5'd0, 5'd2, 5'd3, 3'd2, 32'h00000010);
        chk("bp_full_in_ready", {31'b0, bus.in_ready}, 32'd0);
        drive(3'd5, 5'd1, 5'd5, 5'd0, 3'd3, 32'h00000000);
        bus.in_valid = 1'b1;
        tick();
        head("bp_stall", 32'h0040A283, 1'b0, 16'd10, 16'd3);
        chk("bp_stall_in_ready", {31'b0, bus.in_ready}, 32'd0);
        bus.out_ready = 1'b1;
        tick();
        head("bp_pop1", 32'h00312823, 1'b0, 16'd10, 16'd3);
        chk("bp_pop1_in_ready", {31'b0, bus.in_ready}, 32'd1);
        tick();
        bus.in_valid = 1'b0;
        head("bp_pushpop", 32'h000280E7, 1'b0, 16'd11, 16'd3);
        tick();
        chk("bp_empty", {31'b0, bus.out_valid}, 32'd0);

        // Asynchronous reset with two entries queued.
        bus.out_ready = 1'b0;
        send("ar_lw", 3'd0, 5'd5, 5'd1, 5'd0, 3'd2, 32'h00000004);
        send("ar_beq", 3'd3, 5'd0, 5'd1, 5'd2, 3'd0, 32'h00000003);
        head("ar_pre", 32'h0040A283, 1'b0, 16'd13, 16'd4);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_out_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("ar_out_instr", bus.out_instr, 32'h0);
        chk("ar_out_err", {31'b0, bus.out_err}, 32'd0);
        chk("ar_enc_cnt", {16'b0, enc_cnt}, 32'd0);
        chk("ar_err_cnt", {16'b0, err_cnt}, 32'd0);
        chk("ar_in_ready", {31'b0, bus.in_ready}, 32'd0);
        tick();
        tick();
        rst = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        send("post_lui", 3'd7, 5'd5, 5'd0, 5'd0, 3'd0, 32'h12345000);
        head("post_lui", 32'h123452B7, 1'b0, 16'd1, 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end
endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Inverse of the core's immediate generator. Takes a decoded instruction description (format, register indices, funct3, 32-bit immediate) and builds the RV32I instruction word.
- Checks that the immediate fits the format's range and alignment, and flags it if not.
- Results go through a small output FIFO with valid/ready handshakes on both sides.
- Used by the test-program generator and by the debug/instruction-injection path in front of IM.

Parameters:
- FIFO_DEPTH, 2, number of output FIFO entries; must be a power of 2 and at least 2.
- CNT_W, 16, width of the encode and error counters.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  request valid.
- in_ready  output  1  encoder can accept a request.
- fmt  input  3  format: 0 LOAD, 1 STORE, 2 OPIMM, 3 BRANCH, 4 JAL, 5 JALR, 6 AUIPC, 7 LUI.
- rd  input  5  destination register.
- rs1  input  5  source register 1.
- rs2  input  5  source register 2.
- funct3  input  3  funct3 field.
- imm  input  32  immediate, sign-extended byte offset or upper value.
- out_valid  output  1  FIFO head valid.
- out_ready  input  1  consumer takes the head.
- out_instr  output  32  encoded instruction at the FIFO head.
- out_err  output  1  immediate range/alignment error for the head entry.
- enc_cnt  output  CNT_W  accepted requests; wraps.
- err_cnt  output  CNT_W  accepted requests with error; saturates at all-ones.

Behaviour:
- Reset (async, rst=1): FIFO empty, pointers 0, out_valid=0, out_instr=0, out_err=0, enc_cnt=0, err_cnt=0. in_ready=0 while rst is high. Any in-flight entries are discarded.
- Accept: when in_valid && in_ready at a rising edge. Encoding is combinational on the inputs and the result is written into the FIFO tail.
- in_ready = !full. A pop in the same cycle does not free space for a push while full.
- Pop: when out_valid && out_ready. out_instr/out_err always show the head entry. When empty: out_valid=0, out_instr=0, out_err=0.
- Latency: request accepted at edge N appears with out_valid=1 after edge N when the FIFO was empty. Ordering is strict FIFO.
- Simultaneous push and pop when neither full nor empty: both occur; count unchanged; pointers wrap modulo FIFO_DEPTH.
- Encoding (opcodes 0000011, 0100011, 0010011, 1100011, 1101111, 1100111, 0010111, 0110111 for fmt 0..7):
  - LOAD/OPIMM: {imm[11:0], rs1, funct3, rd, op}.
  - JALR: {imm[11:0], rs1, 3'b000, rd, op}; funct3 input ignored.
  - STORE: {imm[11:5], rs2, rs1, funct3, imm[4:0], op}.
  - BRANCH: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], op}.
  - JAL: {imm[20], imm[10:1], imm[11], imm[19:12], rd, op}.
  - AUIPC/LUI: {imm[31:12], rd, op}.
- Error rules (err=1 when violated):
  - LOAD/STORE/OPIMM/JALR: imm[31:11] all equal.
  - BRANCH: imm[31:12] all equal and imm[0]=0.
  - JAL: imm[31:20] all equal and imm[0]=0.
  - AUIPC/LUI: imm[11:0]=0.
- On error the word is still encoded from the truncated fields and the entry is enqueued with out_err=1. No request is ever dropped.
- Counters: on every accept, enc_cnt+1 (wraps 0xFFFF→0). If err, err_cnt+1, held at 0xFFFF once reached.
- Inputs are don't-care when in_valid=0. Input changes while in_valid && !in_ready have no effect.

Test Plan:
- Reset, then LUI rd=5 imm=0x12345000, out_ready=1 -> next cycle out_valid=1, out_instr=0x123452B7, out_err=0; enc_cnt=1.
- JAL rd=1 imm=8 -> out_instr=0x008000EF, out_err=0.
- BRANCH rs1=1 rs2=2 funct3=0 imm=0xFFFFFFFC -> out_instr=0xFE208EE3. Repeat with imm=0x00000003 -> out_err=1, err_cnt=1.
- OPIMM imm=0x800 (2048) -> out_err=1, err_cnt increments; imm=0xFFFFF800 (-2048) -> out_err=0. LUI imm=0x00001001 -> out_err=1.
- Backpressure: out_ready=0, three back-to-back requests -> first two accepted, in_ready=0 on the third. Raise out_ready -> entries drain in order, then the third is accepted. Push+pop at count=1 keeps count at 1.
- Assert rst asynchronously mid-stream with 2 entries queued -> out_valid, counters and in_ready drop to 0 immediately, without waiting for a clock edge. After release, the first new request is encoded normally with enc_cnt=1.
